// File: rtl/wb_motor_cmd_master_pkg.sv
// Shared definitions for the motor command Wishbone initiator:
// register map of the motor slave, command entry layout, FSM states.
package wb_motor_cmd_master_pkg;

    // Register offsets inside one motor's window
    localparam logic [31:0] CMD_OFS         = 32'h0;
    localparam logic [31:0] STATUS_OFS      = 32'h4;
    localparam int          STATUS_BUSY_BIT = 0;

    // Motors 0..5 exist; 6 and 7 are rejected
    localparam logic [2:0]  MAX_MOTOR       = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_READ,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]  motor;
        logic        dir;
        logic [15:0] steps;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Byte address of a motor's command or status register
    function automatic logic [31:0] motor_adr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [2:0]  motor,
                                              input logic        status);
        return base + stride * {29'b0, motor} + (status ? STATUS_OFS : CMD_OFS);
    endfunction

endpackage

// File: rtl/wb_motor_cmd_fifo.sv
// Small synchronous command queue. A pop and a push may share a cycle
// even when full: the departing head frees the slot being written.
module wb_motor_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_motor_cmd_master.sv
// Wishbone classic initiator: writes queued move commands to the motor
// slave and polls its status register until the move finishes.
module wb_motor_cmd_master
    import wb_motor_cmd_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADR     = 32'h0000_0008,
    parameter int          MOTOR_STRIDE = 8,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          POLL_GAP     = 16,
    parameter int          ACK_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_motor,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_steps,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CNT_MAX = (POLL_GAP > ACK_TIMEOUT) ? POLL_GAP : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state_q, state_d;
    cmd_t          head, cur_q, cmd_in;
    logic          fifo_full, fifo_empty, push, pop;
    logic          load, set_err, ack_ok, tmo, gap_end, bus_active;
    logic [CW-1:0] cnt_q;
    logic          unused_dat;

    assign unused_dat = ^wb_dat_i[31:1];

    assign cmd_in    = '{motor: cmd_motor, dir: cmd_dir, steps: cmd_steps};
    // A pop this cycle frees a slot, so a full queue can still accept
    assign cmd_ready = rst && (!fifo_full || pop);
    assign push      = cmd_valid && cmd_ready;

    wb_motor_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The first cycle of every bus cycle is a forced wait cycle, so an
    // ack is only taken once the counter has moved past zero
    assign ack_ok  = wb_ack_i && (cnt_q != '0);
    assign tmo     = (cnt_q == CW'(ACK_TIMEOUT - 1));
    assign gap_end = (cnt_q == CW'(POLL_GAP - 1));

    // Next-state and queue control
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head.motor > MAX_MOTOR) begin
                        set_err = 1'b1;
                        pop     = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (ack_ok) begin
                    state_d = ST_GAP;
                end else if (tmo) begin
                    set_err = 1'b1;
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_end) state_d = ST_READ;
            end
            ST_READ: begin
                if (ack_ok) begin
                    state_d = wb_dat_i[STATUS_BUSY_BIT] ? ST_GAP : ST_DONE;
                end else if (tmo) begin
                    set_err = 1'b1;
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                pop     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working command, shared gap/timeout counter, sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) cur_q <= head;
            if (state_d != state_q)         cnt_q <= '0;
            else if (cnt_q != CW'(CNT_MAX)) cnt_q <= cnt_q + 1'b1;
            if (set_err) err <= 1'b1;
        end
    end

    // Bus outputs decode straight from state so reset clears them at once
    always_comb begin
        bus_active = (state_q == ST_WRITE) || (state_q == ST_READ);
        wb_cyc_o   = bus_active;
        wb_stb_o   = bus_active;
        wb_we_o    = (state_q == ST_WRITE);
        wb_sel_o   = bus_active ? 4'hF : 4'h0;
        wb_adr_o   = bus_active ? motor_adr(BASE_ADR, 32'(MOTOR_STRIDE), cur_q.motor,
                                            state_q == ST_READ) : 32'h0;
        wb_dat_o   = (state_q == ST_WRITE) ? {15'b0, cur_q.dir, cur_q.steps} : 32'h0;
        done       = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE) || !fifo_empty;
    end

endmodule
